// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the signed-overflow rule applied to the final result.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Overflow of a - b: operand signs differ and the result sign differs from a.
  function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic d_msb);
    return (a_msb != b_msb) && (d_msb != a_msb);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: diff = a - b - bin, with borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one bit per clock through a single
// full-subtractor cell; results are held until the next operation completes.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf,
  output logic             done,
  output logic             busy
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned WRK_W = (WIDTH > 1) ? WIDTH - 1 : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  if (WIDTH < 2) begin : g_width_check
    $error("serial_subtractor: WIDTH must be at least 2");
  end

  state_t             state;
  logic [WIDTH-1:0]   a_sr;
  logic [WIDTH-1:0]   b_sr;
  // Holds bits 0..WIDTH-2 of the result; the last bit comes straight from the cell.
  logic [WRK_W-1:0]   work;
  logic [CNT_W-1:0]   cnt;
  logic               bin_q;
  logic               a_msb;
  logic               b_msb;
  logic               cell_d;
  logic               cell_bout;
  logic               last_bit;

  full_subtractor u_cell (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (bin_q),
    .diff (cell_d),
    .bout (cell_bout)
  );

  assign last_bit    = (cnt == LAST);
  assign start_ready = (state == S_IDLE);
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      work   <= '0;
      cnt    <= '0;
      bin_q  <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_valid) begin
            a_sr  <= a;
            b_sr  <= b;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
            work  <= '0;
            cnt   <= '0;
            bin_q <= 1'b0;
            state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          work  <= WRK_W'({cell_d, work} >> 1);
          bin_q <= cell_bout;
          if (last_bit) begin
            diff   <= {cell_d, work};
            borrow <= cell_bout;
            ovf    <= sub_ovf(a_msb, b_msb, cell_d);
            state  <= S_DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor at WIDTH 2, 8 and 16 against a cycle-count
// arithmetic model, with literal checks on the 8-bit instance.
module tb_serial_subtractor;

  localparam int NI = 3;

  logic            clk;
  logic [NI-1:0]   rst;
  logic [NI-1:0]   sv;
  logic [15:0]     a_in [NI];
  logic [15:0]     b_in [NI];

  wire  [NI-1:0]   rdy;
  wire  [NI-1:0]   bsy;
  wire  [NI-1:0]   dn;
  wire  [NI-1:0]   bor;
  wire  [NI-1:0]   ovf;
  wire  [1:0]      diff2;
  wire  [7:0]      diff8;
  wire  [15:0]     diff16;

  // Model: cycles remaining until ready (0 = idle) plus expected result registers.
  int              rem    [NI];
  logic [15:0]     ea     [NI];
  logic [15:0]     eb     [NI];
  logic [15:0]     m_diff [NI];
  logic            m_bor  [NI];
  logic            m_ovf  [NI];

  int n_cmp;
  int n_bad;

  serial_subtractor #(.WIDTH(2)) u_w2 (
    .clk(clk), .rst(rst[0]), .start_valid(sv[0]), .start_ready(rdy[0]),
    .a(a_in[0][1:0]), .b(b_in[0][1:0]), .diff(diff2), .borrow(bor[0]),
    .ovf(ovf[0]), .done(dn[0]), .busy(bsy[0])
  );

  serial_subtractor #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst[1]), .start_valid(sv[1]), .start_ready(rdy[1]),
    .a(a_in[1][7:0]), .b(b_in[1][7:0]), .diff(diff8), .borrow(bor[1]),
    .ovf(ovf[1]), .done(dn[1]), .busy(bsy[1])
  );

  serial_subtractor #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst(rst[2]), .start_valid(sv[2]), .start_ready(rdy[2]),
    .a(a_in[2]), .b(b_in[2]), .diff(diff16), .borrow(bor[2]),
    .ovf(ovf[2]), .done(dn[2]), .busy(bsy[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wof(input int k);
    case (k)
      0:       return 2;
      1:       return 8;
      default: return 16;
    endcase
  endfunction

  function automatic logic [15:0] get_diff(input int k);
    case (k)
      0:       return 16'(diff2);
      1:       return 16'(diff8);
      default: return diff16;
    endcase
  endfunction

  task automatic check(input string name, input int k, input logic [15:0] act,
                       input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s w=%0d t=%0t: got %h, expected %h", name, wof(k), $time, act, exp);
    end
  endtask

  // Arithmetic reference for one clock edge of instance k.
  task automatic model_edge(input int k);
    int w, half, ua, ub, sa, sb, sd;
    w    = wof(k);
    half = 1 << (w - 1);
    if (rst[k]) begin
      rem[k]    = 0;
      m_diff[k] = '0;
      m_bor[k]  = 1'b0;
      m_ovf[k]  = 1'b0;
    end else if (rem[k] == 0) begin
      if (sv[k]) begin
        ea[k]  = a_in[k] & 16'((1 << w) - 1);
        eb[k]  = b_in[k] & 16'((1 << w) - 1);
        rem[k] = w + 1;
      end
    end else begin
      rem[k]--;
      if (rem[k] == 1) begin
        ua        = int'(ea[k]);
        ub        = int'(eb[k]);
        sa        = (ua >= half) ? ua - (1 << w) : ua;
        sb        = (ub >= half) ? ub - (1 << w) : ub;
        sd        = sa - sb;
        m_diff[k] = 16'((ua - ub) & ((1 << w) - 1));
        m_bor[k]  = (ua < ub);
        m_ovf[k]  = (sd < -half) || (sd > half - 1);
      end
    end
  endtask

  task automatic compare(input int k);
    check("start_ready", k, 16'(rdy[k]), 16'(rem[k] == 0));
    check("busy",        k, 16'(bsy[k]), 16'(rem[k] != 0));
    check("done",        k, 16'(dn[k]),  16'(rem[k] == 1));
    check("diff",        k, get_diff(k), m_diff[k]);
    check("borrow",      k, 16'(bor[k]), 16'(m_bor[k]));
    check("ovf",         k, 16'(ovf[k]), 16'(m_ovf[k]));
  endtask

  // One clock: model follows the edge, outputs are compared on the falling edge.
  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < NI; k++) model_edge(k);
    @(negedge clk);
    for (int k = 0; k < NI; k++) compare(k);
  endtask

  task automatic set_ops(input logic [15:0] av, input logic [15:0] bv);
    for (int k = 0; k < NI; k++) begin
      a_in[k] = av;
      b_in[k] = bv;
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (!(&rdy) && t < 40) begin
      tick();
      t++;
    end
    check("idle_timeout", 1, 16'(&rdy), 16'd1);
  endtask

  // One operation on all instances with literal expectations for WIDTH 8.
  task automatic op(input logic [15:0] av, input logic [15:0] bv, input logic [7:0] ed,
                    input logic eb_l, input logic eo_l);
    sv = '1;
    set_ops(av, bv);
    tick();
    sv = '0;
    for (int t = 1; t <= 9; t++) begin
      tick();
      if (t < 8) check("lit_done_early", 1, 16'(dn[1]), 16'd0);
      if (t == 8) begin
        check("lit_done",   1, 16'(dn[1]), 16'd1);
        check("lit_diff",   1, 16'(diff8), 16'(ed));
        check("lit_borrow", 1, 16'(bor[1]), 16'(eb_l));
        check("lit_ovf",    1, 16'(ovf[1]), 16'(eo_l));
        check("lit_ready8", 1, 16'(rdy[1]), 16'd0);
      end
      if (t == 9) check("lit_ready9", 1, 16'(rdy[1]), 16'd1);
    end
    wait_idle();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    for (int k = 0; k < NI; k++) begin
      rem[k] = 0; ea[k] = '0; eb[k] = '0;
      m_diff[k] = '0; m_bor[k] = 1'b0; m_ovf[k] = 1'b0;
    end

    // Reset held for two edges with start_valid asserted.
    rst = '1;
    sv  = '1;
    set_ops(16'h0035, 16'h0012);
    tick();
    tick();
    check("lit_rst_diff",  1, 16'(diff8), 16'd0);
    check("lit_rst_ready", 1, 16'(rdy[1]), 16'd1);
    check("lit_rst_busy",  1, 16'(bsy[1]), 16'd0);
    check("lit_rst_done",  1, 16'(dn[1]), 16'd0);
    rst = '0;
    sv  = '0;
    tick();

    op(16'h0035, 16'h0012, 8'h23, 1'b0, 1'b0);
    op(16'h0000, 16'h0001, 8'hFF, 1'b1, 1'b0);
    op(16'h0080, 16'h0001, 8'h7F, 1'b0, 1'b1);
    op(16'h007F, 16'h00FF, 8'h80, 1'b1, 1'b1);

    // Back-to-back: start_valid held high with new operands while busy.
    sv = '1;
    set_ops(16'h0035, 16'h0012);
    tick();
    set_ops(16'h00AA, 16'h0055);
    for (int t = 1; t <= 18; t++) begin
      tick();
      if (t >= 8 && t <= 17) check("lit_b2b_hold", 1, 16'(diff8), 16'h0023);
      if (t == 9)  check("lit_b2b_ready", 1, 16'(rdy[1]), 16'd1);
      if (t == 10) check("lit_b2b_taken", 1, 16'(rdy[1]), 16'd0);
      if (t == 18) begin
        check("lit_b2b_diff", 1, 16'(diff8), 16'h0055);
        check("lit_b2b_done", 1, 16'(dn[1]), 16'd1);
      end
    end
    sv = '0;
    wait_idle();

    // Reset in the middle of an operation.
    sv = '1;
    set_ops(16'h0010, 16'h0001);
    tick();
    sv = '0;
    tick();
    tick();
    tick();
    rst = '1;
    tick();
    check("lit_mid_ready", 1, 16'(rdy[1]), 16'd1);
    check("lit_mid_done",  1, 16'(dn[1]), 16'd0);
    check("lit_mid_diff",  1, 16'(diff8), 16'd0);
    rst = '0;
    for (int t = 0; t < 12; t++) tick();
    op(16'h0010, 16'h0001, 8'h0F, 1'b0, 1'b0);

    // Randomized traffic with occasional resets and corner operands.
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < NI; k++) begin
        int w;
        w = wof(k);
        rst[k] = ($urandom_range(0, 59) == 0);
        sv[k]  = ($urandom_range(0, 2) != 0);
        a_in[k] = 16'($urandom);
        b_in[k] = 16'($urandom);
        case ($urandom_range(0, 7))
          0: a_in[k] = 16'(1 << (w - 1));
          1: b_in[k] = 16'(1 << (w - 1));
          2: a_in[k] = 16'((1 << (w - 1)) - 1);
          3: b_in[k] = 16'hFFFF;
          4: a_in[k] = 16'h0000;
          default: ;
        endcase
      end
      tick();
    end
    rst = '0;
    sv  = '0;
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
